// File: rtl/slip_pkg.sv
// Shared SLIP symbol constants and receive-side decoder state encoding.
package slip_pkg;

  localparam int unsigned SLIP_SYMBOL_WIDTH = 8;

  localparam logic [7:0] SLIP_MARK     = 8'hC0;
  localparam logic [7:0] SLIP_ESC      = 8'hDB;
  localparam logic [7:0] SLIP_ESC_MARK = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC  = 8'hDD;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_ESCAPED = 1'b1
  } slip_state_e;

endpackage

// File: rtl/stream_pipe_reg.sv
// Generic one-entry valid/ready register stage; accepts a new word in the same
// cycle the held word is taken, so it sustains one transfer per clock.
module stream_pipe_reg #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_data  = data_q;
  assign out_valid = valid_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/slip_unescaper.sv
// SLIP receive-side unescaper: decodes ESC pairs, flags markers, pulses o_err.
// Optional saturating error counter under `SLIP_UNESCAPER_ERR_COUNT_EN.
module slip_unescaper
  import slip_pkg::*;
#(
  parameter int unsigned             SYMBOL_WIDTH    = SLIP_SYMBOL_WIDTH,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_MARK     = SLIP_MARK,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC      = SLIP_ESC,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC_MARK = SLIP_ESC_MARK,
  parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC_ESC  = SLIP_ESC_ESC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SYMBOL_WIDTH-1:0] i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [SYMBOL_WIDTH-1:0] o_data,
  output logic                    o_mark,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_err
`ifdef SLIP_UNESCAPER_ERR_COUNT_EN
  ,
  output logic [15:0]             o_err_count
`endif
);

  slip_state_e             state_q, state_d;
  logic                    err_q, err_d;
  logic                    accept;
  logic                    in_ready;
  logic                    emit;
  logic                    emit_mark;
  logic [SYMBOL_WIDTH-1:0] emit_data;
  logic [SYMBOL_WIDTH:0]   pipe_data;

  assign o_ready = in_ready;
  assign accept  = i_valid && in_ready;
  assign o_err   = err_q;

  always_comb begin
    state_d   = state_q;
    err_d     = 1'b0;
    emit      = 1'b0;
    emit_mark = 1'b0;
    emit_data = i_data;
    if (accept) begin
      unique case (state_q)
        ST_NORMAL: begin
          if (i_data == SYMBOL_ESC) begin
            state_d = ST_ESCAPED;
          end else begin
            emit      = 1'b1;
            emit_mark = (i_data == SYMBOL_MARK);
          end
        end
        ST_ESCAPED: begin
          state_d = ST_NORMAL;
          if (i_data == SYMBOL_ESC_MARK) begin
            emit      = 1'b1;
            emit_data = SYMBOL_MARK;
          end else if (i_data == SYMBOL_ESC_ESC) begin
            emit      = 1'b1;
            emit_data = SYMBOL_ESC;
          end else if (i_data == SYMBOL_MARK) begin
            // Pass the marker through so the receiver can resynchronise on it.
            err_d     = 1'b1;
            emit      = 1'b1;
            emit_mark = 1'b1;
          end else if (i_data == SYMBOL_ESC) begin
            err_d   = 1'b1;
            state_d = ST_ESCAPED;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_NORMAL;
      endcase
    end
  end

`ifdef SLIP_UNESCAPER_ERR_COUNT_EN
  logic [15:0] err_count_q, err_count_d;

  assign o_err_count = err_count_q;

  always_comb begin
    err_count_d = err_count_q;
    if (err_q && (err_count_q != '1)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NORMAL;
      err_q   <= 1'b0;
`ifdef SLIP_UNESCAPER_ERR_COUNT_EN
      err_count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
`ifdef SLIP_UNESCAPER_ERR_COUNT_EN
      err_count_q <= err_count_d;
`endif
    end
  end

  stream_pipe_reg #(
    .WIDTH(SYMBOL_WIDTH + 1)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({emit_mark, emit_data}),
    .in_valid (emit),
    .in_ready (in_ready),
    .out_data (pipe_data),
    .out_valid(o_valid),
    .out_ready(i_ready)
  );

  assign {o_mark, o_data} = pipe_data;

endmodule

// File: tb/tb_slip_unescaper.sv
// Self-checking bench for slip_unescaper: directed protocol cases plus random
// streams scored against an array-level SLIP decoder and escaper model.
`timescale 1ns/1ps
module tb_slip_unescaper;

  localparam logic [7:0] MARK = 8'hC0;
  localparam logic [7:0] ESC  = 8'hDB;
  localparam logic [7:0] EMK  = 8'hDC;
  localparam logic [7:0] EES  = 8'hDD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b1;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_mark;
  logic       o_valid;
  logic       o_err;
`ifdef SLIP_UNESCAPER_ERR_COUNT_EN
  logic [15:0] o_err_count;
`endif

  slip_unescaper dut (
    .clk    (clk),
    .rst    (rst),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_mark (o_mark),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_err  (o_err)
`ifdef SLIP_UNESCAPER_ERR_COUNT_EN
    ,
    .o_err_count(o_err_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observation log: every output transfer, every input accept, every o_err cycle.
  logic [8:0]  got_q[$];
  logic [7:0]  acc_q[$];
  int unsigned err_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && i_ready) got_q.push_back({o_mark, o_data});
      if (i_valid && o_ready) acc_q.push_back(i_data);
      if (o_err) err_seen++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [7:0] s);
    int unsigned n = 0;
    i_data  = s;
    i_valid = 1'b1;
    @(negedge clk);
    while (!o_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_valid", o_valid, 0);
    check("rst_in_out", {o_err, o_mark, o_data}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_after_valid", o_valid, 0);
    check("rst_after_out", {o_err, o_mark, o_data}, 0);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [8:0] d, input logic e);
    check({tag, "_valid"}, o_valid, v);
    if (v) check({tag, "_data"}, {o_mark, o_data}, d);
    check({tag, "_err"}, o_err, e);
  endtask

  // Whole-stream reference decoder: walks accepted symbols as a SLIP grammar.
  function automatic void decode(input int unsigned from, output logic [8:0] exp[$],
                                 output int unsigned nerr);
    int unsigned i = from;
    int unsigned j;
    exp = {};
    nerr = 0;
    while (i < acc_q.size()) begin
      if (acc_q[i] != ESC) begin
        exp.push_back({acc_q[i] == MARK, acc_q[i]});
        i++;
      end else begin
        j = i + 1;
        while (j < acc_q.size() && acc_q[j] == ESC) begin
          nerr++;
          j++;
        end
        if (j >= acc_q.size()) break;
        if (acc_q[j] == EMK) exp.push_back({1'b0, MARK});
        else if (acc_q[j] == EES) exp.push_back({1'b0, ESC});
        else if (acc_q[j] == MARK) begin
          nerr++;
          exp.push_back({1'b1, MARK});
        end else nerr++;
        i = j + 1;
      end
    end
  endfunction

  function automatic logic [7:0] rand_sym();
    case ($urandom_range(0, 7))
      0: return MARK;
      1: return ESC;
      2: return EMK;
      3: return EES;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic run_random(input logic [7:0] stim[$]);
    bit done = 1'b0;
    fork
      begin
        foreach (stim[k]) begin
          if ($urandom_range(0, 3) == 0) begin
            i_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(stim[k]);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    i_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_stream(input string tag, input int unsigned gb, input logic [8:0] exp[$]);
    int unsigned e0;
    check({tag, "_len"}, got_q.size() - gb, exp.size());
    for (int k = 0; k < exp.size() && (gb + k) < got_q.size(); k++) begin
      e0 = errors;
      check({tag, "_sym"}, got_q[gb + k], exp[k]);
      if (errors != e0) break;
    end
  endtask

  initial begin
    logic [7:0]  stim[$];
    logic [8:0]  exp[$];
    logic [8:0]  raw[$];
    logic [7:0]  d;
    int unsigned gb, ab, eb, nerr;

    do_reset();

    send(MARK);
    expect_out("mark", 1'b1, {1'b1, MARK}, 1'b0);

    send(ESC);
    expect_out("esc_hidden", 1'b0, '0, 1'b0);
    send(8'h55);
    expect_out("esc_bad", 1'b0, '0, 1'b1);
    @(posedge clk);
    #1;
    check("err_one_cycle", o_err, 0);

    send(ESC);
    send(MARK);
    expect_out("esc_mark_err", 1'b1, {1'b1, MARK}, 1'b1);

    send(ESC);
    send(ESC);
    expect_out("esc_esc_err", 1'b0, '0, 1'b1);
    send(EMK);
    expect_out("esc_esc_resync", 1'b1, {1'b0, MARK}, 1'b0);
`ifdef SLIP_UNESCAPER_ERR_COUNT_EN
    check("err_count3", o_err_count, 3);
`endif

    send(8'h11);
    expect_out("s_11", 1'b1, {1'b0, 8'h11}, 1'b0);
    send(ESC);
    send(EMK);
    expect_out("s_escmark", 1'b1, {1'b0, MARK}, 1'b0);
    send(ESC);
    send(EES);
    expect_out("s_escesc", 1'b1, {1'b0, ESC}, 1'b0);
    send(8'h22);
    expect_out("s_22", 1'b1, {1'b0, 8'h22}, 1'b0);

    // Backpressure: hold output while the sink stalls.
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    send(8'h33);
    expect_out("bp_load", 1'b1, {1'b0, 8'h33}, 1'b0);
    i_data  = 8'h44;
    i_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_ready", o_ready, 0);
      check("bp_hold", {o_valid, o_mark, o_data}, {2'b10, 8'h33});
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    send(8'h44);
    expect_out("bp_reload", 1'b1, {1'b0, 8'h44}, 1'b0);

    // Reset in the middle of an escape discards the pending ESC.
    send(ESC);
    do_reset();
    send(EMK);
    expect_out("rst_mid_esc", 1'b1, {1'b0, EMK}, 1'b0);

    // Random junk stream with random valid/ready, scored by the grammar decoder.
    do_reset();
    gb = got_q.size();
    ab = acc_q.size();
    eb = err_seen;
    stim = {};
    for (int k = 0; k < 3000; k++) stim.push_back(rand_sym());
    run_random(stim);
    check("junk_accepts", acc_q.size() - ab, stim.size());
    decode(ab, exp, nerr);
    compare_stream("junk", gb, exp);
    check("junk_errs", err_seen - eb, nerr);
`ifdef SLIP_UNESCAPER_ERR_COUNT_EN
    check("junk_err_count", o_err_count, (nerr > 65535) ? 65535 : nerr);
`endif

    // Round trip: frames escaped by a model escaper must decode to the raw stream.
    do_reset();
    gb = got_q.size();
    eb = err_seen;
    stim = {};
    raw = {};
    while (stim.size() < 10000) begin
      if ($urandom_range(0, 9) == 0) begin
        raw.push_back({1'b1, MARK});
        stim.push_back(MARK);
      end else begin
        d = rand_sym();
        raw.push_back({1'b0, d});
        if (d == MARK) begin
          stim.push_back(ESC);
          stim.push_back(EMK);
        end else if (d == ESC) begin
          stim.push_back(ESC);
          stim.push_back(EES);
        end else begin
          stim.push_back(d);
        end
      end
    end
    run_random(stim);
    compare_stream("trip", gb, raw);
    check("trip_errs", err_seen - eb, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
